// File: rtl/ram_bus_arbiter.sv
// Two-master Wishbone arbiter (fetch m0, load/store m1) sharing one RAM bus; round-robin on ties,
// grant held for the whole cyc. Define RAM_ARB_TIMEOUT_EN to force-release grants stalled without ack.
module ram_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_addr_i,
    input  logic [2:0]  m0_addr_tag_i,
    input  logic [31:0] m0_data_i,
    output logic        m0_ack_o,
    output logic [31:0] m0_data_o,
    output logic        m0_data_tag_o,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_addr_i,
    input  logic [2:0]  m1_addr_tag_i,
    input  logic [31:0] m1_data_i,
    output logic        m1_ack_o,
    output logic [31:0] m1_data_o,
    output logic        m1_data_tag_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_addr_o,
    output logic [2:0]  s_addr_tag_o,
    output logic [31:0] s_data_o,
    input  logic        s_ack_i,
    input  logic [31:0] s_data_i,
    input  logic        s_data_tag_i,
    output logic        timeout_o
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0] state, state_nxt;
    logic       last_grant;
    logic       req0, req1, grant0, grant1, timeout_hit;

    assign req0   = m0_cyc_i & m0_stb_i;
    assign req1   = m1_cyc_i & m1_stb_i;
    assign grant0 = (state == GRANT0);
    assign grant1 = (state == GRANT1);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("ram_bus_arbiter: TIMEOUT_CYCLES must lie within 2..65535");
    end

`ifdef RAM_ARB_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] wait_cnt;
    logic        owner_stb;

    assign owner_stb   = (grant0 & m0_stb_i) | (grant1 & m1_stb_i);
    assign timeout_hit = (grant0 | grant1) & (wait_cnt == TIMEOUT_LIMIT);

    // Counts strobed cycles of the owner that saw no ack; gaps in stb hold the count.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            wait_cnt <= '0;
        else if (!(grant0 | grant1) || s_ack_i || timeout_hit)
            wait_cnt <= '0;
        else if (owner_stb)
            wait_cnt <= wait_cnt + 16'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // On a tie the master that was not granted last wins (last_grant=1 means m0 goes first).
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_grant))
                    state_nxt = GRANT0;
                else if (req1)
                    state_nxt = GRANT1;
            end
            GRANT0: if (!m0_cyc_i || timeout_hit) state_nxt = IDLE;
            GRANT1: if (!m1_cyc_i || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == GRANT0)
                last_grant <= 1'b0;
            else if (state == IDLE && state_nxt == GRANT1)
                last_grant <= 1'b1;
        end
    end

    always_comb begin
        s_cyc_o      = 1'b0;
        s_stb_o      = 1'b0;
        s_we_o       = 1'b0;
        s_sel_o      = '0;
        s_addr_o     = '0;
        s_addr_tag_o = '0;
        s_data_o     = '0;
        if (grant0) begin
            s_cyc_o      = m0_cyc_i & ~timeout_hit;
            s_stb_o      = m0_stb_i & ~timeout_hit;
            s_we_o       = m0_we_i;
            s_sel_o      = m0_sel_i;
            s_addr_o     = m0_addr_i;
            s_addr_tag_o = m0_addr_tag_i;
            s_data_o     = m0_data_i;
        end else if (grant1) begin
            s_cyc_o      = m1_cyc_i & ~timeout_hit;
            s_stb_o      = m1_stb_i & ~timeout_hit;
            s_we_o       = m1_we_i;
            s_sel_o      = m1_sel_i;
            s_addr_o     = m1_addr_i;
            s_addr_tag_o = m1_addr_tag_i;
            s_data_o     = m1_data_i;
        end
    end

    // Responses are suppressed while reset is asserted so an aborted transfer never sees an ack.
    always_comb begin
        m0_ack_o      = 1'b0;
        m0_data_o     = '0;
        m0_data_tag_o = 1'b0;
        m1_ack_o      = 1'b0;
        m1_data_o     = '0;
        m1_data_tag_o = 1'b0;
        if (grant0 && !rst_i) begin
            m0_ack_o      = s_ack_i | timeout_hit;
            m0_data_o     = timeout_hit ? 32'd0 : s_data_i;
            m0_data_tag_o = s_data_tag_i & ~timeout_hit;
        end else if (grant1 && !rst_i) begin
            m1_ack_o      = s_ack_i | timeout_hit;
            m1_data_o     = timeout_hit ? 32'd0 : s_data_i;
            m1_data_tag_o = s_data_tag_i & ~timeout_hit;
        end
    end

    assign timeout_o = timeout_hit;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Scoreboard bench for ram_bus_arbiter: two random masters, a behavioural RAM slave and an ownership model.
// The RAM_ARB_TIMEOUT_EN build swaps the indefinite-stall check for a forced-release check.
module tb_ram_bus_arbiter;
    localparam int TO_CYCLES = 4;

    typedef struct {
        logic [31:0] data;
        logic        tag;
        bit          check_tag;
    } resp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic        m_cyc   [2];
    logic        m_stb   [2];
    logic        m_we    [2];
    logic [3:0]  m_sel   [2];
    logic [31:0] m_addr  [2];
    logic [2:0]  m_tag   [2];
    logic [31:0] m_wdata [2];

    logic        m0_ack, m1_ack, m0_rtag, m1_rtag;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_atag;
    logic        s_ack_i, s_data_tag_i, timeout;
    logic [31:0] s_data_i;
    wire  [1:0]  m_ack_w = {m1_ack, m0_ack};

    int    tests_run = 0;
    int    tests_failed = 0;
    resp_t exp_q0[$];
    resp_t exp_q1[$];
    int    slave_mode = 0;
    int    slave_wait = 0;
    bit    model_on = 1'b0;
    int    own = -1;
    int    last = 1;

    ram_bus_arbiter #(.TIMEOUT_CYCLES(TO_CYCLES)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_we_i(m_we[0]), .m0_sel_i(m_sel[0]),
        .m0_addr_i(m_addr[0]), .m0_addr_tag_i(m_tag[0]), .m0_data_i(m_wdata[0]),
        .m0_ack_o(m0_ack), .m0_data_o(m0_rdata), .m0_data_tag_o(m0_rtag),
        .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_we_i(m_we[1]), .m1_sel_i(m_sel[1]),
        .m1_addr_i(m_addr[1]), .m1_addr_tag_i(m_tag[1]), .m1_data_i(m_wdata[1]),
        .m1_ack_o(m1_ack), .m1_data_o(m1_rdata), .m1_data_tag_o(m1_rtag),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_addr_o(s_addr), .s_addr_tag_o(s_atag), .s_data_o(s_wdata),
        .s_ack_i(s_ack_i), .s_data_i(s_data_i), .s_data_tag_i(s_data_tag_i),
        .timeout_o(timeout)
    );

    function automatic logic [31:0] resp_data(input logic [31:0] addr, input logic [31:0] wdata,
                                              input logic [3:0] sel, input logic we, input logic [2:0] tag);
        return addr ^ {wdata[15:0], wdata[31:16]} ^ {sel, 28'h0} ^ {25'h0, tag, 3'h0, we};
    endfunction

    function automatic logic resp_tag(input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [3:0] sel, input logic we, input logic [2:0] tag);
        return (^{addr, sel, we, tag}) ^ wdata[0];
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_pop(input int n, input logic [31:0] data, input logic tag);
        resp_t r;
        if ((n == 0 && exp_q0.size() == 0) || (n == 1 && exp_q1.size() == 0)) begin
            checkOutput($sformatf("spurious_ack_m%0d", n), 128'(1), 128'(0));
        end else begin
            r = (n == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            checkOutput($sformatf("rdata_m%0d", n), 128'(data), 128'(r.data));
            if (r.check_tag)
                checkOutput($sformatf("rtag_m%0d", n), 128'(tag), 128'(r.tag));
        end
    endtask

    // RAM slave: acks a strobed request after 0..2 cycles, response derived from the request fields.
    initial begin
        s_ack_i = 1'b0;
        s_data_i = '0;
        s_data_tag_i = 1'b0;
        forever begin
            @(posedge clk_i);
            #2;
            if (slave_mode != 1) begin
                s_ack_i = 1'b0;
                s_data_i = $urandom;
                s_data_tag_i = 1'($urandom);
                if (slave_mode == 0 && s_cyc && s_stb) begin
                    if (slave_wait == 0) begin
                        s_ack_i = 1'b1;
                        s_data_i = resp_data(s_addr, s_wdata, s_sel, s_we, s_atag);
                        s_data_tag_i = resp_tag(s_addr, s_wdata, s_sel, s_we, s_atag);
                        slave_wait = $urandom_range(0, 2);
                    end else begin
                        slave_wait--;
                    end
                end
            end
        end
    end

    // Monitor: per-cycle ownership model of the bus plus the response scoreboard.
    initial begin
        forever begin
            logic [127:0] exp_s, exp_r0, exp_r1;
            bit r0, r1;
            @(negedge clk_i);
            if (model_on) begin
                exp_s = '0;
                if (own >= 0)
                    exp_s = 128'({m_cyc[own], m_stb[own], m_we[own], m_sel[own], m_tag[own], m_addr[own], m_wdata[own]});
                checkOutput("s_bus", 128'({s_cyc, s_stb, s_we, s_sel, s_atag, s_addr, s_wdata}), exp_s);
                exp_r0 = (own == 0) ? 128'({s_ack_i, s_data_i, s_data_tag_i}) : 128'(0);
                exp_r1 = (own == 1) ? 128'({s_ack_i, s_data_i, s_data_tag_i}) : 128'(0);
                checkOutput("m0_resp", 128'({m0_ack, m0_rdata, m0_rtag}), exp_r0);
                checkOutput("m1_resp", 128'({m1_ack, m1_rdata, m1_rtag}), exp_r1);
                checkOutput("timeout_quiet", 128'(timeout), 128'(0));
                if (own < 0) begin
                    r0 = m_cyc[0] && m_stb[0];
                    r1 = m_cyc[1] && m_stb[1];
                    if (r0 && r1)      own = (last == 1) ? 0 : 1;
                    else if (r0)       own = 0;
                    else if (r1)       own = 1;
                    if (own >= 0) last = own;
                end else if (!m_cyc[own]) begin
                    own = -1;
                end
            end
            if (m0_ack) check_pop(0, m0_rdata, m0_rtag);
            if (m1_ack) check_pop(1, m1_rdata, m1_rtag);
        end
    end

    task automatic applyStimulus(input int n, input int count);
        for (int t = 0; t < count; t++) begin
            int    beats;
            bit    abort_it;
            int    waited;
            bit    got;
            resp_t r;
            beats = $urandom_range(1, 3);
            abort_it = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 3)) @(posedge clk_i);
            @(posedge clk_i);
            #1;
            m_cyc[n] = 1'b1;
            for (int b = 0; b < beats; b++) begin
                if (b > 0 && $urandom_range(0, 2) == 0) begin
                    m_stb[n] = 1'b0;
                    @(posedge clk_i);
                    #1;
                end
                m_we[n] = 1'($urandom);
                m_sel[n] = 4'($urandom);
                m_addr[n] = $urandom;
                m_tag[n] = 3'($urandom);
                m_wdata[n] = $urandom;
                m_stb[n] = 1'b1;
                r.data = resp_data(m_addr[n], m_wdata[n], m_sel[n], m_we[n], m_tag[n]);
                r.tag = resp_tag(m_addr[n], m_wdata[n], m_sel[n], m_we[n], m_tag[n]);
                r.check_tag = 1'b1;
                if (n == 0) exp_q0.push_back(r); else exp_q1.push_back(r);
                got = 1'b0;
                waited = 0;
                while (!got) begin
                    @(negedge clk_i);
                    if (m_ack_w[n]) begin
                        got = 1'b1;
                    end else begin
                        waited++;
                        if (abort_it && waited >= 2) break;
                        if (waited > 300) begin
                            checkOutput($sformatf("ack_wait_m%0d", n), 128'(0), 128'(1));
                            break;
                        end
                        @(posedge clk_i);
                        #1;
                    end
                end
                @(posedge clk_i);
                #1;
                if (!got) begin
                    if (n == 0) void'(exp_q0.pop_back()); else void'(exp_q1.pop_back());
                    break;
                end
            end
            m_cyc[n] = 1'b0;
            m_stb[n] = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: still running at %0t, expected finish before 500000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0; m_sel[i] = '0;
            m_addr[i] = '0; m_tag[i] = '0; m_wdata[i] = '0;
        end
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_ctrl", 128'({s_cyc, s_stb, s_we, s_sel, s_atag, m0_ack, m1_ack, m0_rtag, m1_rtag, timeout}), 128'(0));
        checkOutput("reset_sbus", 128'({s_addr, s_wdata}), 128'(0));
        checkOutput("reset_mdata", 128'({m0_rdata, m1_rdata}), 128'(0));

        own = -1;
        last = 1;
        model_on = 1'b1;
        fork
            applyStimulus(0, 40);
            applyStimulus(1, 40);
        join
        repeat (3) @(posedge clk_i);
        #1;

`ifdef RAM_ARB_TIMEOUT_EN
        model_on = 1'b0;
        slave_mode = 2;
        exp_q0.push_back('{data: 32'd0, tag: 1'b0, check_tag: 1'b0});
        m_addr[0] = 32'h0000_0100; m_we[0] = 1'b0; m_sel[0] = 4'hF; m_tag[0] = 3'b000;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk_i);
            checkOutput($sformatf("to_pulse_%0d", k), 128'(timeout), 128'(k == 5));
            checkOutput($sformatf("to_ack_%0d", k), 128'(m0_ack), 128'(k == 5));
            checkOutput($sformatf("to_scyc_%0d", k), 128'({s_cyc, s_stb}), (k >= 1 && k <= 4) ? 128'(3) : 128'(0));
        end
        @(posedge clk_i);
        #1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(negedge clk_i);
        checkOutput("to_released", 128'({s_cyc, timeout, m0_ack}), 128'(0));
        slave_mode = 0;
        @(posedge clk_i);
        #1;
`else
        slave_mode = 2;
        m_addr[0] = 32'h0000_0100; m_we[0] = 1'b0; m_sel[0] = 4'hF; m_tag[0] = 3'b000;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_i);
            checkOutput("stall_no_ack", 128'({m0_ack, timeout}), 128'(0));
        end
        @(posedge clk_i);
        #1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        @(negedge clk_i);
        checkOutput("abort_scyc", 128'({s_cyc, s_stb}), 128'(0));
        slave_mode = 0;
        @(posedge clk_i);
        #1;
        model_on = 1'b0;
`endif

        // Reset in the middle of a granted transfer with ack already on the bus.
        slave_mode = 1;
        s_ack_i = 1'b0;
        m_addr[0] = 32'h0000_0200; m_tag[0] = 3'b101;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        @(posedge clk_i);
        #1;
        s_ack_i = 1'b1;
        s_data_i = 32'hDEAD_BEEF;
        rst_i = 1'b1;
        @(negedge clk_i);
        checkOutput("rst_no_ack", 128'({m0_ack, m1_ack}), 128'(0));
        @(posedge clk_i);
        #1;
        @(negedge clk_i);
        checkOutput("rst_ctrl_zero", 128'({s_cyc, s_stb, s_we, s_sel, s_atag, m0_ack, m1_ack, m0_rtag, m1_rtag, timeout}), 128'(0));
        checkOutput("rst_data_zero", 128'({s_addr, s_wdata, m0_rdata, m1_rdata}), 128'(0));
        rst_i = 1'b0;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        s_ack_i = 1'b0;
        slave_mode = 0;
        repeat (2) @(posedge clk_i);

        checkOutput("q0_drained", 128'(exp_q0.size()), 128'(0));
        checkOutput("q1_drained", 128'(exp_q1.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
